// File: rtl/select_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : select_sequencer_if
// Purpose : Button inputs and the downstream req/ack configuration channel
//           that belong to select_sequencer.
// Revision: 1.0
// ============================================================================
interface select_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       btn;
    logic             cfg_ack;
    logic [WIDTH-1:0] number;
    logic [WIDTH-1:0] cfg_value;
    logic             cfg_req;
    logic             busy;
    logic             err;

    modport master (
        input  btn, cfg_ack,
        output number, cfg_value, cfg_req, busy, err
    );

    modport slave (
        output btn, cfg_ack,
        input  number, cfg_value, cfg_req, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/select_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : select_sequencer
// Purpose : Debounced up/down selection index committed through a 4-phase
//           req/ack handshake with timeout. Optional hold-to-repeat when
//           AUTO_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
module select_sequencer #(
    parameter int WIDTH        = 4,
    parameter int MAX_VALUE    = 9,
    parameter int SAMPLE_DIV   = 1048576,
    parameter int TIMEOUT      = 255,
    parameter int REPEAT_DELAY = 24,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                clk,
    input  logic                reset,
    select_sequencer_if.master  bus
);
    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_VALUE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    logic [PW-1:0]    ps_cnt;
    logic             tick;
    logic [1:0]       btn_s;
    logic [1:0]       btn_d;
    logic [1:0]       press_evt;
    logic [1:0]       evt;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [WIDTH-1:0] number_r, number_n;
    logic [WIDTH-1:0] value_r, value_n;
    logic             req_r, req_n;
    logic             err_r, err_n;

    assign tick = (ps_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
            btn_s  <= '0;
            btn_d  <= '0;
        end else begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
            if (tick) begin
                btn_s <= bus.btn;
            end
            btn_d <= btn_s;
        end
    end

    // btn_s only moves on a tick, so each rising edge lasts exactly one cycle
    assign press_evt = btn_s & ~btn_d;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [1:0] rpt_evt;

    for (genvar g = 0; g < 2; g++) begin : g_repeat
        logic [RW-1:0] cnt;
        logic          repeating;
        logic          pulse;

        // Counts ticks across which the button stays held; first repeat after
        // the delay, later ones at the repeat rate.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt       <= '0;
                repeating <= 1'b0;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (!btn_s[g]) begin
                    cnt       <= '0;
                    repeating <= 1'b0;
                end else if (tick && bus.btn[g]) begin
                    if (cnt == (repeating ? RATE_LAST : DELAY_LAST)) begin
                        cnt       <= '0;
                        repeating <= 1'b1;
                        pulse     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign rpt_evt[g] = pulse;
    end

    assign evt = press_evt | rpt_evt;
`else
    assign evt = press_evt;
`endif

    assign inc_val = (number_r == MAXV) ? '0 : number_r + 1'b1;
    assign dec_val = (number_r == '0) ? MAXV : number_r - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            number_r <= '0;
            value_r  <= '0;
            req_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            number_r <= number_n;
            value_r  <= value_n;
            req_r    <= req_n;
            err_r    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        number_n = number_r;
        value_n  = value_r;
        req_n    = req_r;
        err_n    = 1'b0;
        case (state)
            S_IDLE: begin
                // inc has priority; events arriving outside IDLE are simply lost
                if (|evt) begin
                    value_n = evt[0] ? inc_val : dec_val;
                    req_n   = 1'b1;
                    timer_n = '0;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                timer_n = timer + 1'b1;
                if (bus.cfg_ack) begin
                    req_n    = 1'b0;
                    number_n = value_r;
                    state_n  = S_RELEASE;
                end else if (timer == T_LAST) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.cfg_ack) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.number    = number_r;
    assign bus.cfg_value = value_r;
    assign bus.cfg_req   = req_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_select_sequencer
// Purpose : Randomized self-checking bench for select_sequencer with an
//           index model and a configurable ack responder.
// Revision: 1.0
// ============================================================================
module tb_select_sequencer;
    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int SD   = 4;
    localparam int TO   = 8;
    localparam int RD   = 24;
    localparam int RR   = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    select_sequencer_if #(.WIDTH(W)) bus ();

    select_sequencer #(
        .WIDTH(W), .MAX_VALUE(MAXV), .SAMPLE_DIV(SD),
        .TIMEOUT(TO), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int model_n = 0;
    int ack_delay = 2;   // -1 = never acknowledge
    int ack_hold  = 0;
    int pc;              // where the sample prescaler is expected to be

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 0;
        else       pc <= (pc == SD - 1) ? 0 : pc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int next_val(input int n, input bit up);
        return up ? (n + 1) % (MAXV + 1) : (n + MAXV) % (MAXV + 1);
    endfunction

    // Ack responder: rises ack_delay cycles after seeing req, drops ack_hold
    // cycles after req falls.
    initial begin
        int rc, rh;
        rc = 0; rh = 0;
        bus.cfg_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.cfg_ack = 1'b0; rc = 0; rh = 0;
            end else if (!bus.cfg_ack) begin
                if (bus.cfg_req && ack_delay >= 0) begin
                    if (rc >= ack_delay) begin bus.cfg_ack = 1'b1; rh = 0; end
                    else rc++;
                end else rc = 0;
            end else if (!bus.cfg_req) begin
                if (rh >= ack_hold) begin bus.cfg_ack = 1'b0; rc = 0; end
                else rh++;
            end
        end
    end

    // Holds b across exactly one sample tick; returns one cycle after the event
    task automatic start_press(input logic [1:0] b);
        @(negedge clk);
        bus.btn = b;
        while (pc != 0) @(negedge clk);
        @(negedge clk);
        bus.btn = 2'b00;
        check("no_req_in_event_cycle", int'(bus.cfg_req), 0);
        @(negedge clk);
    endtask

    task automatic finish_txn(input int d, input int exp_val, input int old_n);
        int hi, errs, guard;
        hi = 0; errs = 0; guard = 0;
        check("req_rise", int'(bus.cfg_req), 1);
        check("cfg_value", int'(bus.cfg_value), exp_val);
        while (bus.cfg_req && guard < 100) begin
            hi++; guard++;
            if (bus.err) errs++;
            @(negedge clk);
        end
        if (d >= 0) begin
            check("req_len_ack", hi, d + 1);
            check("number_commit", int'(bus.number), exp_val);
        end else begin
            check("req_len_timeout", hi, TO);
            check("number_hold", int'(bus.number), old_n);
        end
        guard = 0;
        while (bus.busy && guard < 100) begin
            if (bus.err) errs++;
            guard++;
            @(negedge clk);
        end
        check("err_pulses", errs, (d < 0) ? 1 : 0);
        check("busy_low", int'(bus.busy), 0);
        check("value_held", int'(bus.cfg_value), exp_val);
    endtask

    task automatic idle_gap();
        int reqs;
        reqs = 0;
        repeat (2 * SD + 2) begin
            @(negedge clk);
            if (bus.cfg_req) reqs++;
        end
        check("no_spurious_req", reqs, 0);
    endtask

    task automatic txn(input logic [1:0] b, input int d);
        int exp_val, old_n;
        ack_delay = d;
        old_n   = model_n;
        exp_val = next_val(model_n, b[0]);
        start_press(b);
        finish_txn(d, exp_val, old_n);
        if (d >= 0) model_n = exp_val;
        idle_gap();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.btn = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_number", int'(bus.number), 0);
        check("rst_cfg_req", int'(bus.cfg_req), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_cfg_value", int'(bus.cfg_value), 0);
        reset = 1'b0;

        // Single increment, then wrap both ways
        txn(2'b01, 2);
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        model_n = 0;
        check("number_after_reset", int'(bus.number), 0);
        txn(2'b10, 2);
        txn(2'b01, 2);

        // Simultaneous inc/dec from 5: inc wins
        while (model_n != 5) txn(2'b01, 0);
        txn(2'b11, 2);

        // Silent responder
        txn(2'b01, -1);

        // Second press while a request is outstanding is dropped
        begin
            int exp_val;
            ack_delay = 5;
            exp_val = next_val(model_n, 1'b1);
            start_press(2'b01);
            bus.btn = 2'b10;
            finish_txn(5, exp_val, model_n);
            model_n = exp_val;
            bus.btn = 2'b00;
            idle_gap();
        end

        for (int i = 0; i < 30; i++) begin
            logic [1:0] b;
            int d;
            b = 2'($urandom_range(1, 3));
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            ack_hold = int'($urandom_range(0, 3));
            txn(b, d);
        end
        ack_hold = 0;

`ifdef AUTO_REPEAT_EN
        begin
            int steps, exp_steps, prev;
            ack_delay = 0;
            steps = 0; exp_steps = 0;
            for (int k = 0; k < 40; k++)
                if (k == 0 || (k >= RD && (k - RD) % RR == 0)) exp_steps++;
            @(negedge clk);
            bus.btn = 2'b01;
            while (pc != 0) @(negedge clk);
            prev = int'(bus.number);
            repeat (40 * SD) begin
                @(negedge clk);
                if (int'(bus.number) != prev) begin steps++; prev = int'(bus.number); end
            end
            bus.btn = 2'b00;
            repeat (10) begin
                @(negedge clk);
                if (int'(bus.number) != prev) begin steps++; prev = int'(bus.number); end
            end
            check("repeat_steps", steps, exp_steps);
            model_n = (model_n + exp_steps) % (MAXV + 1);
            check("repeat_number", int'(bus.number), model_n);
            idle_gap();
        end
`endif

        // Reset in the middle of a handshake
        if (model_n == 0) txn(2'b01, 1);
        ack_delay = -1;
        start_press(2'b01);
        check("req_before_reset", int'(bus.cfg_req), 1);
        reset = 1'b1;
        #1;
        check("async_rst_req", int'(bus.cfg_req), 0);
        check("async_rst_number", int'(bus.number), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * SD) @(negedge clk);
        check("post_rst_number", int'(bus.number), 0);
        check("post_rst_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
